// File: rtl/mips_pkg.sv
// mips_pkg: run-controller state encoding and shared core defaults
package mips_pkg;
  localparam int DEF_PC_W = 32;
  typedef enum logic [2:0] {IDLE, RST_HOLD, RUN, HALTED, TIMEOUT} state_t;
endpackage

// File: rtl/mips_run_ctrl_sat_counter.sv
// sat_counter: up-counter with enable and sync clear that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (clr) q <= '0;
    else if (en && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: reset sequencing, cycle/write counting and halt/watchdog stop for the mips core
module mips_run_ctrl import mips_pkg::*; #(
  parameter int RST_CYCLES  = 4,
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 100000,
  parameter int HALT_REPEAT = 4,
  parameter int PC_W        = DEF_PC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             grf_we,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] wr_count
);
  localparam int RW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  localparam int HW = $clog2(HALT_REPEAT);
  localparam logic [63:0] WD = 64'(MAX_CYCLES - 1);
  state_t state, nxt;
  logic [RW-1:0] rcnt;
  logic [HW-1:0] scnt;
  logic [PC_W-1:0] pc_prev;
  logic pv, go, same, halt, wd;
  assign go = start && (state == IDLE || state == HALTED || state == TIMEOUT);
  assign same = pv && pc == pc_prev;
  // scnt holds matches already seen; this cycle's match makes HALT_REPEAT-1
  assign halt = state == RUN && same && scnt == HW'(HALT_REPEAT - 2);
  assign wd = state == RUN && 64'(cycle_count) == WD;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = go ? RST_HOLD
        : state == RST_HOLD && rcnt == RW'(RST_CYCLES - 1) ? RUN
        : halt ? HALTED
        : wd ? TIMEOUT
        : state;
  always_comb begin
    cpu_reset = state != RUN;
    running = state == RUN;
    done = state == HALTED;
    timeout = state == TIMEOUT;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rcnt <= '0;
      scnt <= '0;
      pc_prev <= '0;
      pv <= 1'b0;
    end else if (go) begin
      rcnt <= '0;
      scnt <= '0;
      pv <= 1'b0;
    end else begin
      if (state == RST_HOLD) rcnt <= rcnt + 1'b1;
      if (state == RUN) begin
        pc_prev <= pc;
        pv <= 1'b1;
        scnt <= same ? scnt + 1'b1 : '0;
      end
    end
  sat_counter #(.W(CNT_W)) u_cyc (
    .clk(clk), .reset(reset), .clr(go), .en(state == RUN), .q(cycle_count)
  );
  sat_counter #(.W(CNT_W)) u_wr (
    .clk(clk), .reset(reset), .clr(go), .en(state == RUN && grf_we), .q(wr_count)
  );
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: randomized and directed runs scored against a pc-stream reference model
module tb_mips_run_ctrl;
  localparam int RSTC = 4;
  localparam int MAXC = 20;
  localparam int HR = 4;
  typedef struct {bit done; int cyc; int wr;} exp_t;
  logic clk = 0, rst_n = 0, start = 0, grf_we = 0;
  logic [31:0] pc = 0;
  logic cpu_reset, running, done, timeout;
  logic [31:0] cycle_count, wr_count;
  logic c2_cpu_reset, c2_running, c2_done, c2_timeout;
  logic [3:0] c2_cycle_count, c2_wr_count;
  logic [31:0] pcs [MAXC];
  bit wes [MAXC];
  exp_t sbq[$];
  int n_chk = 0, n_fail = 0;
  logic ended_q = 0;
  always #5 clk = ~clk;
  mips_run_ctrl #(.RST_CYCLES(RSTC), .CNT_W(32), .MAX_CYCLES(MAXC), .HALT_REPEAT(HR), .PC_W(32)) u1 (
    .clk(clk), .reset(rst_n), .start(start), .pc(pc), .grf_we(grf_we),
    .cpu_reset(cpu_reset), .running(running), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .wr_count(wr_count)
  );
  mips_run_ctrl #(.RST_CYCLES(RSTC), .CNT_W(4), .MAX_CYCLES(1000), .HALT_REPEAT(HR), .PC_W(32)) u2 (
    .clk(clk), .reset(rst_n), .start(start), .pc(pc), .grf_we(grf_we),
    .cpu_reset(c2_cpu_reset), .running(c2_running), .done(c2_done), .timeout(c2_timeout),
    .cycle_count(c2_cycle_count), .wr_count(c2_wr_count)
  );
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // a run stops at the first cycle whose pc has been unchanged for HR cycles, or after MAXC cycles
  function automatic exp_t model();
    exp_t e;
    int rl = 0;
    e.done = 0;
    e.cyc = MAXC;
    e.wr = 0;
    for (int k = 0; k < MAXC; k++) begin
      rl = (k > 0 && pcs[k] == pcs[k-1]) ? rl + 1 : 1;
      e.wr += int'(wes[k]);
      if (rl >= HR || k == MAXC - 1) begin
        e.done = rl >= HR;
        e.cyc = k + 1;
        return e;
      end
    end
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if ((done || timeout) && !ended_q) begin
      if (sbq.size() == 0) chk("unexpected_end", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("end_done", done, e.done);
        chk("end_timeout", timeout, !e.done);
        chk("end_cycle_count", cycle_count, e.cyc);
        chk("end_wr_count", wr_count, e.wr);
      end
    end
    ended_q <= done || timeout;
  end
  task automatic do_run(output exp_t e);
    int n, k;
    e = model();
    sbq.push_back(e);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("clr_cycle_count", cycle_count, 0);
    chk("clr_wr_count", wr_count, 0);
    chk("clr_flags", {done, timeout}, 0);
    n = 0;
    while (!running && n < 20) begin
      if (!cpu_reset) chk("hold_cpu_reset", cpu_reset, 1);
      n++;
      @(negedge clk);
    end
    chk("rst_hold_len", n, RSTC);
    chk("run_cpu_reset", cpu_reset, 0);
    k = 0;
    while (running && k < MAXC) begin
      pc = pcs[k];
      grf_we = wes[k];
      k++;
      @(negedge clk);
    end
    grf_we = 0;
    repeat (10) @(negedge clk);
    chk("frozen_cycle_count", cycle_count, e.cyc);
    chk("frozen_wr_count", wr_count, e.wr);
    chk("frozen_state", {running, cpu_reset}, 2'b01);
  endtask
  initial begin
    exp_t e;
    int pat;
    #1000000 $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end
  initial begin
    exp_t e;
    logic [11:0] wpat;
    repeat (2) @(negedge clk);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_flags", {running, done, timeout}, 0);
    chk("rst_counts", cycle_count + wr_count, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_cpu_reset", cpu_reset, 1);
    // halt on a stuck pc after a short climb
    for (int k = 0; k < MAXC; k++) begin
      pcs[k] = 32'h3000 + 32'(4 * (k < 4 ? k : 4));
      wes[k] = 1'(k % 2);
    end
    do_run(e);
    // never-stuck pc runs into the watchdog; the 4-bit twin saturates
    for (int k = 0; k < MAXC; k++) begin
      pcs[k] = 32'h400 + 32'(4 * k);
      wes[k] = 1;
    end
    do_run(e);
    chk("sat_cycle_count", c2_cycle_count, 15);
    chk("sat_wr_count", c2_wr_count, 15);
    chk("sat_done", c2_done, 1);
    // 7 writes in 12 cycles, then stuck
    wpat = 12'b1011_0101_1001;
    for (int k = 0; k < MAXC; k++) begin
      pcs[k] = 32'h100 + 32'(4 * (k < 11 ? k : 11));
      wes[k] = k < 12 ? wpat[11-k] : 1'b0;
    end
    do_run(e);
    // halt completes on the watchdog cycle
    for (int k = 0; k < MAXC; k++) begin
      pcs[k] = 32'h800 + 32'(4 * (k < 16 ? k : 16));
      wes[k] = 0;
    end
    do_run(e);
    for (int r = 0; r < 15; r++) begin
      pcs[0] = $urandom & 32'hffff_fffc;
      wes[0] = 1'($urandom_range(0, 1));
      for (int k = 1; k < MAXC; k++) begin
        pcs[k] = $urandom_range(0, 2) == 0 ? pcs[k-1] : pcs[k-1] + 32'd4;
        wes[k] = 1'($urandom_range(0, 1));
      end
      do_run(e);
    end
    // start mid-run is ignored; reset mid-run clears at once
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    while (!running) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      pc = 32'h5000 + 32'(4 * k);
      grf_we = 1;
      start = k == 5;
      @(negedge clk);
    end
    start = 0;
    chk("midrun_cycle_count", cycle_count, 10);
    chk("midrun_wr_count", wr_count, 10);
    chk("midrun_running", running, 1);
    #2 rst_n = 0;
    #1;
    chk("async_cpu_reset", cpu_reset, 1);
    chk("async_running", running, 0);
    chk("async_counts", cycle_count + wr_count, 0);
    chk("async_flags", {done, timeout}, 0);
    @(negedge clk) rst_n = 1;
    grf_we = 0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {running, cpu_reset}, 2'b01);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
